// File: rtl/aquila_bus_pkg.sv
// Shared definitions for the Aquila data/instruction bus routers:
// transaction state encoding and the default SoC segment map.
package aquila_bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    ERR  = 2'd2
  } bus_state_e;

  localparam logic [3:0] SEG_TCM   = 4'h0;
  localparam logic [3:0] SEG_DDR   = 4'h8;
  localparam logic [3:0] SEG_DEV   = 4'hC;
  localparam logic [3:0] SEG_CLINT = 4'hF;

endpackage

// File: rtl/aquila_seg_decoder.sv
// Combinational segment decoder: compares the address MSBs against each
// slave's base/mask pair and reports the lowest-index hit.
module aquila_seg_decoder #(
  parameter int ADDR_WIDTH = 32,
  parameter int N_SLAVES   = 4,
  parameter int SEG_WIDTH  = 4,
  parameter int SEL_WIDTH  = 2,
  parameter logic [N_SLAVES*SEG_WIDTH-1:0] SLAVE_BASES = '0,
  parameter logic [N_SLAVES*SEG_WIDTH-1:0] SLAVE_MASKS = '0
) (
  input  logic [ADDR_WIDTH-1:0] addr_i,
  output logic [N_SLAVES-1:0]   hit_vec_o,
  output logic                  hit_o,
  output logic [SEL_WIDTH-1:0]  sel_o
);

  logic [SEG_WIDTH-1:0] seg;
  logic                 unused_low_bits;

  assign seg             = addr_i[ADDR_WIDTH-1 -: SEG_WIDTH];
  assign unused_low_bits = ^addr_i[ADDR_WIDTH-SEG_WIDTH-1:0];

  // Scanning from the top down lets the lowest matching index win.
  always_comb begin
    hit_vec_o = '0;
    hit_o     = 1'b0;
    sel_o     = '0;
    for (int k = N_SLAVES - 1; k >= 0; k--) begin
      if ((seg & SLAVE_MASKS[k*SEG_WIDTH +: SEG_WIDTH]) ==
          (SLAVE_BASES[k*SEG_WIDTH +: SEG_WIDTH] & SLAVE_MASKS[k*SEG_WIDTH +: SEG_WIDTH])) begin
        hit_vec_o[k] = 1'b1;
        hit_o        = 1'b1;
        sel_o        = SEL_WIDTH'(k);
      end
    end
  end

endmodule

// File: rtl/aquila_dbus_router.sv
// Data-side bus router: decodes the core request onto one of N_SLAVES ports,
// tracks the transaction, and reports unmapped/timeout errors with sticky capture.
module aquila_dbus_router
  import aquila_bus_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int N_SLAVES   = 4,
  parameter int SEG_WIDTH  = 4,
  parameter logic [N_SLAVES*SEG_WIDTH-1:0] SLAVE_BASES = {SEG_CLINT, SEG_DEV, SEG_DDR, SEG_TCM},
  parameter logic [N_SLAVES*SEG_WIDTH-1:0] SLAVE_MASKS = {4'hF, 4'hF, 4'hC, 4'hF},
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       p_req_i,
  input  logic                       p_rw_i,
  input  logic [ADDR_WIDTH-1:0]      p_addr_i,
  input  logic [DATA_WIDTH/8-1:0]    p_byte_enable_i,
  input  logic [DATA_WIDTH-1:0]      p_data_i,
  output logic [DATA_WIDTH-1:0]      p_data_o,
  output logic                       p_ready_o,
  output logic                       p_error_o,
  output logic [N_SLAVES-1:0]        s_strobe_o,
  output logic                       s_rw_o,
  output logic [ADDR_WIDTH-1:0]      s_addr_o,
  output logic [DATA_WIDTH/8-1:0]    s_byte_enable_o,
  output logic [DATA_WIDTH-1:0]      s_data_o,
  input  logic [N_SLAVES*DATA_WIDTH-1:0] s_data_i,
  input  logic [N_SLAVES-1:0]        s_ready_i,
  output logic                       err_valid_o,
  output logic [ADDR_WIDTH-1:0]      err_addr_o,
  output logic                       err_timeout_o,
  input  logic                       err_clear_i
);

  localparam int BE_WIDTH  = DATA_WIDTH / 8;
  localparam int SEL_WIDTH = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;
  localparam int CNT_WIDTH = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  bus_state_e               state_q, state_d;
  logic [SEL_WIDTH-1:0]     sel_q, sel_d;
  logic [ADDR_WIDTH-1:0]    addr_q, addr_d;
  logic [DATA_WIDTH-1:0]    data_q, data_d;
  logic [BE_WIDTH-1:0]      be_q, be_d;
  logic                     rw_q, rw_d;
  logic [N_SLAVES-1:0]      strobe_q, strobe_d;
  logic [CNT_WIDTH-1:0]     cnt_q, cnt_d;
  logic                     err_valid_q, err_valid_d;
  logic [ADDR_WIDTH-1:0]    err_addr_q, err_addr_d;
  logic                     err_timeout_q, err_timeout_d;

  logic [N_SLAVES-1:0]      unused_hit_vec;
  logic                     dec_hit;
  logic [SEL_WIDTH-1:0]     dec_sel;
  logic                     busy, slv_ready, timeout_hit, err_event;
  logic [DATA_WIDTH-1:0]    slv_data;

  aquila_seg_decoder #(
    .ADDR_WIDTH  (ADDR_WIDTH),
    .N_SLAVES    (N_SLAVES),
    .SEG_WIDTH   (SEG_WIDTH),
    .SEL_WIDTH   (SEL_WIDTH),
    .SLAVE_BASES (SLAVE_BASES),
    .SLAVE_MASKS (SLAVE_MASKS)
  ) u_decoder (
    .addr_i    (p_addr_i),
    .hit_vec_o (unused_hit_vec),
    .hit_o     (dec_hit),
    .sel_o     (dec_sel)
  );

  assign busy        = (state_q == BUSY);
  assign slv_ready   = s_ready_i[sel_q];
  assign slv_data    = s_data_i[sel_q*DATA_WIDTH +: DATA_WIDTH];
  // Ready from the selected slave takes priority over an expiring timeout.
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && busy && !slv_ready &&
                       (cnt_q == CNT_WIDTH'(TIMEOUT_CYCLES));
  assign err_event   = (state_q == ERR) || timeout_hit;

  always_comb begin
    p_ready_o = (busy && (slv_ready || timeout_hit)) || (state_q == ERR);
    p_error_o = err_event;
    p_data_o  = '0;
    if (busy && slv_ready && !rw_q) begin
      p_data_o = slv_data;
    end
  end

  always_comb begin
    state_d       = state_q;
    sel_d         = sel_q;
    addr_d        = addr_q;
    data_d        = data_q;
    be_d          = be_q;
    rw_d          = rw_q;
    strobe_d      = '0;
    cnt_d         = cnt_q;
    err_valid_d   = err_valid_q;
    err_addr_d    = err_addr_q;
    err_timeout_d = err_timeout_q;

    case (state_q)
      IDLE: begin
        if (p_req_i) begin
          addr_d = p_addr_i;
          data_d = p_data_i;
          be_d   = p_byte_enable_i;
          rw_d   = p_rw_i;
          sel_d  = dec_sel;
          if (dec_hit) begin
            strobe_d[dec_sel] = 1'b1;
            cnt_d             = CNT_WIDTH'(1);
            state_d           = BUSY;
          end else begin
            state_d = ERR;
          end
        end
      end
      BUSY: begin
        if (slv_ready || timeout_hit) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
        end
      end
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // A clear coinciding with a new error still lets the new error be captured.
    if (err_clear_i) begin
      err_valid_d = 1'b0;
    end
    if (err_event && (!err_valid_q || err_clear_i)) begin
      err_valid_d   = 1'b1;
      err_addr_d    = addr_q;
      err_timeout_d = timeout_hit;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      sel_q         <= '0;
      addr_q        <= '0;
      data_q        <= '0;
      be_q          <= '0;
      rw_q          <= 1'b0;
      strobe_q      <= '0;
      cnt_q         <= '0;
      err_valid_q   <= 1'b0;
      err_addr_q    <= '0;
      err_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      sel_q         <= sel_d;
      addr_q        <= addr_d;
      data_q        <= data_d;
      be_q          <= be_d;
      rw_q          <= rw_d;
      strobe_q      <= strobe_d;
      cnt_q         <= cnt_d;
      err_valid_q   <= err_valid_d;
      err_addr_q    <= err_addr_d;
      err_timeout_q <= err_timeout_d;
    end
  end

  assign s_strobe_o      = strobe_q;
  assign s_addr_o        = addr_q;
  assign s_data_o        = data_q;
  assign s_byte_enable_o = be_q;
  assign s_rw_o          = rw_q;
  assign err_valid_o     = err_valid_q;
  assign err_addr_o      = err_addr_q;
  assign err_timeout_o   = err_timeout_q;

endmodule
